// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte-addressed requests into word-addressed, lane-masked ram
// accesses and returns extended load data. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 31,
    parameter int unsigned DATA_WIDTH = 31,
    parameter int unsigned MEM_WORDS  = 2049
) (
    input  logic                  clk,
    input  logic                  rst,
    // request channel
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_wdata,
    // response channel
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [31:0]           o_resp_rdata,
    output logic                  o_resp_err,
    output logic                  o_resp_misaligned,
    // ram ports
    output logic                  o_mem_clk_en,
    output logic                  o_mem_read_enable,
    output logic [ADDR_WIDTH:0]   o_mem_read_addr,
    output logic [3:0]            o_mem_write_enable,
    output logic [3:0]            o_mem_byte_enable,
    output logic [ADDR_WIDTH:0]   o_mem_write_addr,
    output logic [DATA_WIDTH:0]   o_mem_write_data,
    input  logic [DATA_WIDTH:0]   i_mem_read_data
);

    localparam int unsigned AddrBits = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoadWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    logic [29:0] word_idx;
    logic [1:0]  size;
    logic        funct3_legal;
    logic        out_of_range;
    logic        misaligned;
    logic        req_err;
    logic        accept;
    logic        issue;
    logic [3:0]  mask;
    logic [31:0] wdata_rep;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    assign word_idx = i_req_addr[31:2];
    assign size     = i_req_funct3[1:0];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        funct3_legal = 1'b0;
        if (i_req_we) begin
            unique case (i_req_funct3)
                3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
                default:                funct3_legal = 1'b0;
            endcase
        end else begin
            unique case (i_req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_legal = 1'b1;
                default:                                funct3_legal = 1'b0;
            endcase
        end
    end

    // Full 30-bit word index is compared so high addresses never alias into the ram.
    assign out_of_range = {2'b00, word_idx} >= MEM_WORDS;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        if (funct3_legal) begin
            if (size == 2'b01 && i_req_addr[0]) begin
                misaligned = 1'b1;
            end
            if (size == 2'b10 && i_req_addr[1:0] != 2'b00) begin
                misaligned = 1'b1;
            end
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    assign req_err = !funct3_legal || out_of_range || misaligned;
    assign accept  = i_req_valid && o_req_ready;
    // Gating with rst keeps the ram quiet while the state register is held in reset.
    assign issue   = accept && !req_err && !rst;

    always_comb begin
        mask = 4'b0000;
        case (size)
            2'b00:   mask = 4'b0001 << i_req_addr[1:0];
            2'b01:   mask = 4'b0011 << {i_req_addr[1], 1'b0};
            2'b10:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
    end

    always_comb begin
        wdata_rep = i_req_wdata;
        case (size)
            2'b00:   wdata_rep = {4{i_req_wdata[7:0]}};
            2'b01:   wdata_rep = {2{i_req_wdata[15:0]}};
            default: wdata_rep = i_req_wdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Ram access (combinational in the accept cycle)
    // ------------------------------------------------------------------
    assign o_mem_clk_en       = 1'b1;
    assign o_mem_read_enable  = issue && !i_req_we;
    assign o_mem_write_enable = (issue && i_req_we) ? mask : 4'b0000;
    assign o_mem_byte_enable  = o_mem_write_enable;
    assign o_mem_read_addr    = AddrBits'(word_idx);
    assign o_mem_write_addr   = AddrBits'(word_idx);
    assign o_mem_write_data   = wdata_rep;

    // ------------------------------------------------------------------
    // Load data extraction from the registered request attributes
    // ------------------------------------------------------------------
    always_comb begin
        load_byte = i_mem_read_data[7:0];
        case (offset_q)
            2'b00:   load_byte = i_mem_read_data[7:0];
            2'b01:   load_byte = i_mem_read_data[15:8];
            2'b10:   load_byte = i_mem_read_data[23:16];
            default: load_byte = i_mem_read_data[31:24];
        endcase
    end

    assign load_half = offset_q[1] ? i_mem_read_data[31:16] : i_mem_read_data[15:0];

    always_comb begin
        load_ext = i_mem_read_data;
        case (funct3_q)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_ext = {24'h000000, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b101:  load_ext = {16'h0000, load_half};
            default: load_ext = i_mem_read_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        offset_d = offset_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mis_d    = mis_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    funct3_d = i_req_funct3;
                    offset_d = i_req_addr[1:0];
                    rdata_d  = 32'h0000_0000;
                    err_d    = req_err;
                    mis_d    = misaligned;
                    state_d  = (issue && !i_req_we) ? StLoadWait : StResp;
                end
            end
            StLoadWait: begin
                rdata_d = load_ext;
                state_d = StResp;
            end
            StResp: begin
                if (i_resp_ready) begin
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b0;
                    mis_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            funct3_q <= 3'b000;
            offset_q <= 2'b00;
            rdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            offset_q <= offset_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            mis_q    <= mis_d;
        end
    end

    assign o_req_ready       = (state_q == StIdle);
    assign o_resp_valid      = (state_q == StResp);
    assign o_resp_rdata      = rdata_q;
    assign o_resp_err        = err_q;
    assign o_resp_misaligned = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural ram plus a byte-level golden memory; responses are
// checked against a scoreboard queue filled when each request is accepted.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 2049;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;
    logic        o_resp_misaligned;
    logic        o_mem_clk_en;
    logic        o_mem_read_enable;
    logic [31:0] o_mem_read_addr;
    logic [3:0]  o_mem_write_enable;
    logic [3:0]  o_mem_byte_enable;
    logic [31:0] o_mem_write_addr;
    logic [31:0] o_mem_write_data;
    logic [31:0] i_mem_read_data;

    int checks;
    int errors;

    exp_t sb[$];
    exp_t mon_e;

    logic [31:0] ram [0:MEM_WORDS-1];
    logic [7:0]  gold [0:4*MEM_WORDS-1];
    logic [11:0] ridx;
    logic [11:0] widx;

    logic        obs_re;
    logic [3:0]  obs_we;
    logic [3:0]  obs_be;
    logic [31:0] obs_raddr;
    logic [31:0] obs_waddr;
    logic [31:0] obs_wdata;

    load_store_unit #(
        .ADDR_WIDTH(31),
        .DATA_WIDTH(31),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_req_valid       (i_req_valid),
        .o_req_ready       (o_req_ready),
        .i_req_we          (i_req_we),
        .i_req_funct3      (i_req_funct3),
        .i_req_addr        (i_req_addr),
        .i_req_wdata       (i_req_wdata),
        .o_resp_valid      (o_resp_valid),
        .i_resp_ready      (i_resp_ready),
        .o_resp_rdata      (o_resp_rdata),
        .o_resp_err        (o_resp_err),
        .o_resp_misaligned (o_resp_misaligned),
        .o_mem_clk_en      (o_mem_clk_en),
        .o_mem_read_enable (o_mem_read_enable),
        .o_mem_read_addr   (o_mem_read_addr),
        .o_mem_write_enable(o_mem_write_enable),
        .o_mem_byte_enable (o_mem_byte_enable),
        .o_mem_write_addr  (o_mem_write_addr),
        .o_mem_write_data  (o_mem_write_data),
        .i_mem_read_data   (i_mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ram: synchronous read, per-lane write.
    assign ridx = o_mem_read_addr[11:0];
    assign widx = o_mem_write_addr[11:0];

    always @(posedge clk) begin
        if (o_mem_read_enable && o_mem_read_addr < MEM_WORDS) begin
            i_mem_read_data <= ram[ridx];
        end
        if (o_mem_write_addr < MEM_WORDS) begin
            for (int l = 0; l < 4; l++) begin
                if (o_mem_write_enable[l]) begin
                    ram[widx][8*l +: 8] <= o_mem_write_data[8*l +: 8];
                end
            end
        end
    end

    // Scoreboard: every consumed response is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && o_resp_valid && i_resp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected got rdata=%h err=%b mis=%b with no request pending",
                         o_resp_rdata, o_resp_err, o_resp_misaligned);
            end else begin
                mon_e = sb.pop_front();
                if ({o_resp_rdata, o_resp_err, o_resp_misaligned} !== mon_e) begin
                    errors++;
                    $display("FAIL resp_data got rdata=%h err=%b mis=%b want rdata=%h err=%b mis=%b",
                             o_resp_rdata, o_resp_err, o_resp_misaligned,
                             mon_e.rdata, mon_e.err, mon_e.mis);
                end
            end
        end
    end

    // Reference behaviour on a byte-addressed golden memory.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e);
        logic        legal;
        logic        mis;
        logic [31:0] w;
        int          base;
        int          off;
        logic [7:0]  b;
        logic [15:0] h;
        if (we) legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        else    legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                         f3 == 3'b100 || f3 == 3'b101);
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (legal && f3[1:0] == 2'b01 && a[0]) mis = 1'b1;
        if (legal && f3[1:0] == 2'b10 && a[1:0] != 2'b00) mis = 1'b1;
`endif
        w       = {2'b00, a[31:2]};
        e.rdata = 32'h0;
        e.mis   = mis;
        e.err   = !legal || (w >= MEM_WORDS) || mis;
        if (e.err) return;
        base = int'(w) * 4;
        case (f3[1:0])
            2'b00:   off = int'(a[1:0]);
            2'b01:   off = a[1] ? 2 : 0;
            default: off = 0;
        endcase
        if (we) begin
            gold[base+off] = wd[7:0];
            if (f3[1:0] != 2'b00) gold[base+off+1] = wd[15:8];
            if (f3[1:0] == 2'b10) begin
                gold[base+2] = wd[23:16];
                gold[base+3] = wd[31:24];
            end
        end else begin
            b = gold[base+off];
            case (f3)
                3'b000: e.rdata = {{24{b[7]}}, b};
                3'b100: e.rdata = {24'h0, b};
                3'b001: begin
                    h       = {gold[base+off+1], gold[base+off]};
                    e.rdata = {{16{h[15]}}, h};
                end
                3'b101: begin
                    h       = {gold[base+off+1], gold[base+off]};
                    e.rdata = {16'h0, h};
                end
                default: e.rdata = {gold[base+3], gold[base+2], gold[base+1], gold[base]};
            endcase
        end
    endtask

    // Drive one request with i_resp_ready=1; record accept-cycle strobes and response latency.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = a;
        i_req_wdata  = wd;
        n = 0;
        @(negedge clk);
        while (!o_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got ready=0 want ready=1 within 20 cycles");
            i_req_valid = 1'b0;
            lat = -1;
            return;
        end
        obs_re    = o_mem_read_enable;
        obs_we    = o_mem_write_enable;
        obs_be    = o_mem_byte_enable;
        obs_raddr = o_mem_read_addr;
        obs_waddr = o_mem_write_addr;
        obs_wdata = o_mem_write_data;
        model(we, f3, a, wd, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_resp_valid && lat < 20);
        if (!o_resp_valid) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout got valid=0 want valid=1 within 20 cycles");
            return;
        end
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        i_resp_ready = 1'b1;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h10;
        i_req_wdata  = 32'h0;
        @(negedge clk);
        checks++;
        if ({o_resp_valid, o_resp_err, o_resp_misaligned} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000",
                     {o_resp_valid, o_resp_err, o_resp_misaligned});
        end
        checks++;
        if (o_resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 00000000", o_resp_rdata);
        end
        checks++;
        if (o_mem_read_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_read_en got %b want 0", o_mem_read_enable);
        end
        i_req_we = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_mem_write_enable, o_mem_byte_enable} !== 8'h00) begin
            errors++;
            $display("FAIL reset_write_en got %b want 00000000",
                     {o_mem_write_enable, o_mem_byte_enable});
        end
        i_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_req_ready, o_resp_valid, o_mem_clk_en} !== 3'b101) begin
            errors++;
            $display("FAIL post_reset got ready/valid/clk_en=%b want 101",
                     {o_req_ready, o_resp_valid, o_mem_clk_en});
        end
    endtask

    task automatic test_store_word;
        int lat;
        issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, lat);
        checks++;
        if (obs_waddr !== 32'd4 || obs_be !== 4'b1111 || obs_we !== 4'b1111 || obs_re !== 1'b0) begin
            errors++;
            $display("FAIL sw_strobes got waddr=%h be=%b we=%b re=%b want 4 1111 1111 0",
                     obs_waddr, obs_be, obs_we, obs_re);
        end
        checks++;
        if (obs_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_wdata got %h want deadbeef", obs_wdata);
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL sw_latency got %0d want 1", lat);
        end
        issue(1'b0, 3'b010, 32'h10, 32'h0, lat);
        checks++;
        if (obs_re !== 1'b1 || obs_raddr !== 32'd4 || obs_we !== 4'b0000) begin
            errors++;
            $display("FAIL lw_strobes got re=%b raddr=%h we=%b want 1 4 0000",
                     obs_re, obs_raddr, obs_we);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL lw_latency got %0d want 2", lat);
        end
    endtask

    task automatic test_byte;
        int lat;
        issue(1'b1, 3'b000, 32'h13, 32'h0000_00A5, lat);
        checks++;
        if (obs_be !== 4'b1000 || obs_we !== 4'b1000 || obs_wdata !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL sb_lane got be=%b we=%b wdata=%h want 1000 1000 a5a5a5a5",
                     obs_be, obs_we, obs_wdata);
        end
        issue(1'b0, 3'b000, 32'h13, 32'h0, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL lb_latency got %0d want 2", lat);
        end
        issue(1'b0, 3'b100, 32'h13, 32'h0, lat);
        issue(1'b0, 3'b000, 32'h10, 32'h0, lat);
        issue(1'b0, 3'b100, 32'h11, 32'h0, lat);
    endtask

    task automatic test_half;
        int lat;
        issue(1'b1, 3'b001, 32'h22, 32'h0000_8001, lat);
        checks++;
        if (obs_be !== 4'b1100 || obs_wdata !== 32'h8001_8001 || obs_waddr !== 32'd8) begin
            errors++;
            $display("FAIL sh_hi got be=%b wdata=%h waddr=%h want 1100 80018001 8",
                     obs_be, obs_wdata, obs_waddr);
        end
        issue(1'b1, 3'b001, 32'h20, 32'hFFFF_1234, lat);
        checks++;
        if (obs_be !== 4'b0011 || obs_wdata !== 32'h1234_1234) begin
            errors++;
            $display("FAIL sh_lo got be=%b wdata=%h want 0011 12341234", obs_be, obs_wdata);
        end
        issue(1'b0, 3'b001, 32'h22, 32'h0, lat);
        issue(1'b0, 3'b101, 32'h22, 32'h0, lat);
        issue(1'b0, 3'b001, 32'h20, 32'h0, lat);
        issue(1'b0, 3'b010, 32'h20, 32'h0, lat);
    endtask

    task automatic test_errors;
        int lat;
        issue(1'b0, 3'b011, 32'h10, 32'h0, lat);
        checks++;
        if (obs_re !== 1'b0 || obs_we !== 4'b0000 || lat !== 1) begin
            errors++;
            $display("FAIL illegal_load got re=%b we=%b lat=%0d want 0 0000 1", obs_re, obs_we, lat);
        end
        issue(1'b0, 3'b010, 32'(4 * MEM_WORDS), 32'h0, lat);
        checks++;
        if (obs_re !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL range_load got re=%b lat=%0d want 0 1", obs_re, lat);
        end
        issue(1'b1, 3'b011, 32'h10, 32'h5555_5555, lat);
        checks++;
        if (obs_we !== 4'b0000 || obs_be !== 4'b0000 || lat !== 1) begin
            errors++;
            $display("FAIL illegal_store got we=%b be=%b lat=%0d want 0000 0000 1",
                     obs_we, obs_be, lat);
        end
        issue(1'b1, 3'b100, 32'h10, 32'h5555_5555, lat);
        issue(1'b0, 3'b110, 32'h10, 32'h0, lat);
        issue(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, lat);
        checks++;
        if (obs_re !== 1'b0) begin
            errors++;
            $display("FAIL nowrap_load got re=%b want 0", obs_re);
        end
        issue(1'b0, 3'b010, 32'(4 * (MEM_WORDS - 1)), 32'h0, lat);
        checks++;
        if (obs_re !== 1'b1 || obs_raddr !== 32'(MEM_WORDS - 1) || lat !== 2) begin
            errors++;
            $display("FAIL last_word got re=%b raddr=%h lat=%0d want 1 %h 2",
                     obs_re, obs_raddr, lat, 32'(MEM_WORDS - 1));
        end
        issue(1'b0, 3'b010, 32'h10, 32'h0, lat);
    endtask

    task automatic test_misaligned;
        int lat;
        issue(1'b1, 3'b010, 32'h100, 32'h1122_3344, lat);
        issue(1'b0, 3'b001, 32'h101, 32'h0, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if (obs_re !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL mis_lh got re=%b lat=%0d want 0 1", obs_re, lat);
        end
`else
        checks++;
        if (obs_re !== 1'b1 || obs_raddr !== 32'h40 || lat !== 2) begin
            errors++;
            $display("FAIL mis_lh got re=%b raddr=%h lat=%0d want 1 40 2", obs_re, obs_raddr, lat);
        end
`endif
        issue(1'b0, 3'b010, 32'h102, 32'h0, lat);
        issue(1'b1, 3'b001, 32'h103, 32'h0000_BEEF, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if (obs_we !== 4'b0000) begin
            errors++;
            $display("FAIL mis_sh got we=%b want 0000", obs_we);
        end
`else
        checks++;
        if (obs_we !== 4'b1100) begin
            errors++;
            $display("FAIL mis_sh got we=%b want 1100", obs_we);
        end
`endif
        issue(1'b0, 3'b010, 32'h100, 32'h0, lat);
    endtask

    task automatic test_back_to_back;
        exp_t held;
        exp_t e2;
        int   n;
        int   lat;
        @(posedge clk);
        #1;
        i_resp_ready = 1'b0;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h10;
        @(negedge clk);
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_ready got %b want 1", o_req_ready);
        end
        model(1'b0, 3'b010, 32'h10, 32'h0, held);
        sb.push_back(held);
        @(posedge clk);
        #1;
        i_req_we     = 1'b1;
        i_req_addr   = 32'h30;
        i_req_wdata  = 32'hCAFE_F00D;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_resp_valid && n < 10);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (o_resp_valid !== 1'b1 || o_req_ready !== 1'b0 || o_resp_rdata !== held.rdata ||
                o_mem_write_enable !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got valid=%b ready=%b rdata=%h we=%b want 1 0 %h 0000",
                         c, o_resp_valid, o_req_ready, o_resp_rdata, o_mem_write_enable,
                         held.rdata);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        i_resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (o_req_ready !== 1'b0 || o_mem_write_enable !== 4'b0000) begin
            errors++;
            $display("FAIL bp_handshake_cycle got ready=%b we=%b want 0 0000",
                     o_req_ready, o_mem_write_enable);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_req_ready !== 1'b1 || o_mem_write_enable !== 4'b1111) begin
            errors++;
            $display("FAIL bp_next_accept got ready=%b we=%b want 1 1111",
                     o_req_ready, o_mem_write_enable);
        end
        model(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, e2);
        sb.push_back(e2);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_resp_valid !== 1'b1 || o_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_store_resp got valid=%b ready=%b want 1 0", o_resp_valid, o_req_ready);
        end
        @(posedge clk);
        issue(1'b0, 3'b010, 32'h30, 32'h0, lat);
    endtask

    task automatic test_reset_mid_load;
        @(posedge clk);
        #1;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h10;
        @(negedge clk);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_load got valid=%b ready=%b want 0 1", o_resp_valid, o_req_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (o_resp_valid !== 1'b0 || o_mem_write_enable !== 4'b0000) begin
                errors++;
                $display("FAIL rst_after cyc %0d got valid=%b we=%b want 0 0000",
                         c, o_resp_valid, o_mem_write_enable);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < MEM_WORDS; i++) ram[i] = 32'h0;
        for (int i = 0; i < 4 * MEM_WORDS; i++) gold[i] = 8'h00;
        test_reset();
        test_store_word();
        test_byte();
        test_half();
        test_errors();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_load();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1);
    end

endmodule
